// File: rtl/fsk_pkg.sv
// Shared widths, phase type and FSK source encodings for the FSK phase accumulator.
package fsk_pkg;

    localparam int PHASE_W = 42;
    localparam int ADDR_W  = 14;

    typedef logic [PHASE_W-1:0] phase_t;

    localparam logic FSK_SRC_INT = 1'b0;
    localparam logic FSK_SRC_EXT = 1'b1;

endpackage

// File: rtl/fsk_rate_sel.sv
// FSK selection: internal rate timer, external-pin synchronizer and the FskSel register.
module fsk_rate_sel
    import fsk_pkg::*;
#(
    parameter int RATE_W = 32
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              En,
    input  logic              PhaseRst,
    input  logic              FskEn,
    input  logic              FskSrc,
    input  logic              FskExt,
    input  logic [RATE_W-1:0] RateDiv,
    output logic              FskSel
);

    logic [RATE_W-1:0] cnt;
    logic              sync1, sync2;
    logic              fsk_en_q, fsk_src_q;
    logic              mode_chg;

    assign mode_chg = (FskEn != fsk_en_q) || (FskSrc != fsk_src_q);

    // NOTE: every register here is assigned with <= so all flops sample the same pre-edge values.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt       <= '0;
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            fsk_en_q  <= 1'b0;
            fsk_src_q <= 1'b0;
            FskSel    <= 1'b0;
        end else begin
            sync1     <= FskExt;
            sync2     <= sync1;
            fsk_en_q  <= FskEn;
            fsk_src_q <= FskSrc;
            if (!FskEn) begin
                cnt    <= '0;
                FskSel <= 1'b0;
            end else if (FskSrc == FSK_SRC_EXT) begin
                // External mode ignores En and PhaseRst; the timer idles at zero.
                cnt    <= '0;
                FskSel <= sync2;
            end else if (PhaseRst) begin
                cnt    <= '0;
                FskSel <= 1'b0;
            end else if (mode_chg) begin
                cnt <= '0;
            end else if (En) begin
                if (cnt == RateDiv) begin
                    cnt    <= '0;
                    FskSel <= ~FskSel;
                end else begin
                    cnt <= cnt + RATE_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/fsk_phase_accum.sv
// Phase-continuous FSK DDS phase accumulator with waveform address and wrap strobe.
// Optional build macro FSK_PHASE_OFFSET_EN adds a registered PhaseOff address offset.
module fsk_phase_accum #(
    parameter int PHASE_W = fsk_pkg::PHASE_W,
    parameter int ADDR_W  = fsk_pkg::ADDR_W,
    parameter int RATE_W  = 32
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               En,
    input  logic               PhaseRst,
`ifdef FSK_PHASE_OFFSET_EN
    input  logic [ADDR_W-1:0]  PhaseOff,
`endif
    input  logic [PHASE_W-1:0] Inc0,
    input  logic [PHASE_W-1:0] Inc1,
    input  logic               FskEn,
    input  logic               FskSrc,
    input  logic               FskExt,
    input  logic [RATE_W-1:0]  RateDiv,
    output logic [PHASE_W-1:0] Phase,
    output logic [ADDR_W-1:0]  Addr,
    output logic               FskSel,
    output logic               Wrap
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] inc_reg;
    logic [PHASE_W:0]   sum;
    logic               wrap_q;
    logic               fsk_sel;

    fsk_rate_sel #(
        .RATE_W (RATE_W)
    ) u_rate_sel (
        .Clock    (Clock),
        .Reset    (Reset),
        .En       (En),
        .PhaseRst (PhaseRst),
        .FskEn    (FskEn),
        .FskSrc   (FskSrc),
        .FskExt   (FskExt),
        .RateDiv  (RateDiv),
        .FskSel   (fsk_sel)
    );

    assign sum = {1'b0, phase_q} + {1'b0, inc_reg};

    // inc_reg decouples the increment mux from the adder; switching only changes
    // the step size, so the phase never jumps.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            phase_q <= '0;
            inc_reg <= '0;
            wrap_q  <= 1'b0;
        end else begin
            inc_reg <= fsk_sel ? Inc1 : Inc0;
            if (PhaseRst) begin
                phase_q <= '0;
                wrap_q  <= 1'b0;
            end else if (En) begin
                phase_q <= sum[PHASE_W-1:0];
                wrap_q  <= sum[PHASE_W];
            end else begin
                wrap_q  <= 1'b0;
            end
        end
    end

    assign Phase  = phase_q;
    assign FskSel = fsk_sel;

`ifdef FSK_PHASE_OFFSET_EN
    logic [ADDR_W-1:0] addr_q;
    logic              wrap_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            addr_q <= '0;
            wrap_d <= 1'b0;
        end else begin
            addr_q <= phase_q[PHASE_W-1 -: ADDR_W] + PhaseOff;
            wrap_d <= wrap_q;
        end
    end

    assign Addr = addr_q;
    assign Wrap = wrap_d;
`else
    assign Addr = phase_q[PHASE_W-1 -: ADDR_W];
    assign Wrap = wrap_q;
`endif

endmodule

// File: tb/tb_fsk_phase_accum.sv
// Randomized self-checking bench for fsk_phase_accum against a behavioural cycle model.
module tb_fsk_phase_accum;
    import fsk_pkg::*;

    localparam int RATE_W = 32;
    localparam logic [63:0] PH_MASK = (64'd1 << PHASE_W) - 64'd1;

    logic              Clock = 1'b0;
    logic              Reset = 1'b0;
    logic              En = 1'b0;
    logic              PhaseRst = 1'b0;
    phase_t            Inc0 = '0;
    phase_t            Inc1 = '0;
    logic              FskEn = 1'b0;
    logic              FskSrc = 1'b0;
    logic              FskExt = 1'b0;
    logic [RATE_W-1:0] RateDiv = '0;
    phase_t            Phase;
    logic [ADDR_W-1:0] Addr;
    logic              FskSel;
    logic              Wrap;

    int checks = 0;
    int errors = 0;

    fsk_phase_accum dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .En       (En),
        .PhaseRst (PhaseRst),
`ifdef FSK_PHASE_OFFSET_EN
        .PhaseOff ('0),
`endif
        .Inc0     (Inc0),
        .Inc1     (Inc1),
        .FskEn    (FskEn),
        .FskSrc   (FskSrc),
        .FskExt   (FskExt),
        .RateDiv  (RateDiv),
        .Phase    (Phase),
        .Addr     (Addr),
        .FskSel   (FskSel),
        .Wrap     (Wrap)
    );

    always #5 Clock = ~Clock;

    // Reference model state: phase as plain 64-bit arithmetic, increment chosen one
    // edge earlier, external level seen two edges late, timer as an elapsed count.
    logic [63:0] m_phase;
    logic [63:0] m_step;
    logic        m_wrap;
    logic        m_sel;
    logic [31:0] m_elapsed;
    logic        ext_hist [2];
    logic [1:0]  m_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [63:0] total;
        logic        nsel;
        if (!Reset) begin
            m_phase = 0; m_step = 0; m_wrap = 0; m_sel = 0; m_elapsed = 0;
            ext_hist[0] = 0; ext_hist[1] = 0; m_mode = 2'b00;
            return;
        end
        nsel = m_sel;
        if (!FskEn) begin
            nsel = 0; m_elapsed = 0;
        end else if (FskSrc) begin
            nsel = ext_hist[1]; m_elapsed = 0;
        end else if (PhaseRst) begin
            nsel = 0; m_elapsed = 0;
        end else if ({FskEn, FskSrc} != m_mode) begin
            m_elapsed = 0;
        end else if (En) begin
            if (m_elapsed == RateDiv) begin
                m_elapsed = 0; nsel = !m_sel;
            end else begin
                m_elapsed = m_elapsed + 1;
            end
        end
        if (PhaseRst) begin
            m_phase = 0; m_wrap = 0;
        end else if (En) begin
            total   = m_phase + m_step;
            m_wrap  = (total > PH_MASK);
            m_phase = total & PH_MASK;
        end else begin
            m_wrap = 0;
        end
        m_step = m_sel ? 64'(Inc1) : 64'(Inc0);
        m_sel = nsel;
        ext_hist[1] = ext_hist[0];
        ext_hist[0] = FskExt;
        m_mode = {FskEn, FskSrc};
    endtask

    task automatic step();
        @(posedge Clock);
        model_edge();
        #1;
        check("phase", 64'(Phase), m_phase);
        check("addr", 64'(Addr), m_phase >> (PHASE_W - ADDR_W));
        check("fsksel", 64'(FskSel), 64'(m_sel));
        check("wrap", 64'(Wrap), 64'(m_wrap));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int wraps;
    int toggles;
    logic last_sel;

    initial begin
        // Reset with accumulation requested
        Reset = 0; En = 1; Inc0 = 42'h3FF; Inc1 = 42'h3FF;
        run(3);
        check("rst_phase", 64'(Phase), 64'd0);
        check("rst_fsksel", 64'(FskSel), 64'd0);
        Reset = 1;
        step();
        check("first_edge_phase", 64'(Phase), 64'd0);
        step();
        check("second_edge_phase", 64'(Phase), 64'h3FF);

        // Fixed increment 2^32: two wraps every 2048 cycles from zero
        Inc0 = 42'h1_0000_0000; Inc1 = 42'h1_0000_0000; PhaseRst = 1;
        run(2);
        PhaseRst = 0;
        wraps = 0;
        for (int i = 0; i < 2048; i++) begin
            step();
            if (Wrap) wraps++;
            if (i == 0) check("step_2p32_addr", 64'(Addr), 64'd16);
        end
        check("wrap_count_2p32", 64'(wraps), 64'd2);

        // Internal rate timer, RateDiv=3, with an En=0 hold
        FskEn = 1; FskSrc = FSK_SRC_INT; RateDiv = 3; Inc0 = 1; Inc1 = 3;
        run(2);
        toggles = 0; last_sel = FskSel;
        for (int i = 0; i < 16; i++) begin
            step();
            if (FskSel != last_sel) toggles++;
            last_sel = FskSel;
        end
        check("int_toggles_16", 64'(toggles), 64'd4);
        En = 0;
        run(2);
        En = 1;
        run(20);

        // External pin through the synchronizer, plus a short unsampled pulse
        FskSrc = FSK_SRC_EXT;
        for (int i = 0; i < 40; i++) begin
            FskExt = 1'($urandom_range(0, 1));
            step();
        end
        FskExt = 0;
        run(4);
        FskExt = 1; #2; FskExt = 0;
        run(4);
        check("ext_glitch_ignored", 64'(FskSel), 64'd0);

        // All-ones increment: carry on every add after the first
        FskEn = 0; Inc0 = '1; Inc1 = '1; PhaseRst = 1;
        run(2);
        PhaseRst = 0;
        step();
        check("ones_phase1", 64'(Phase), 64'h3FF_FFFF_FFFF);
        check("ones_wrap1", 64'(Wrap), 64'd0);
        step();
        check("ones_phase2", 64'(Phase), 64'h3FF_FFFF_FFFE);
        check("ones_wrap2", 64'(Wrap), 64'd1);
        run(3);
        check("ones_wrap_steady", 64'(Wrap), 64'd1);

        // PhaseRst mid-run with En=1
        FskEn = 1; FskSrc = FSK_SRC_INT; RateDiv = 1000; Inc0 = 42'h123; Inc1 = 42'h123;
        PhaseRst = 1;
        run(2);
        PhaseRst = 0;
        step();
        check("prst_pre_phase", 64'(Phase), 64'h123);
        PhaseRst = 1;
        step();
        check("prst_phase", 64'(Phase), 64'd0);
        check("prst_fsksel", 64'(FskSel), 64'd0);
        PhaseRst = 0;
        step();
        check("prst_resume", 64'(Phase), 64'h123);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            Reset    = ($urandom_range(0, 499) != 0);
            En       = ($urandom_range(0, 7) != 0);
            PhaseRst = ($urandom_range(0, 99) == 0);
            FskExt   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                Inc0 = {10'($urandom), 32'($urandom)};
                Inc1 = {10'($urandom), 32'($urandom)};
            end
            if ($urandom_range(0, 59) == 0) begin
                FskEn   = 1'($urandom_range(0, 1));
                FskSrc  = 1'($urandom_range(0, 1));
                if (!FskEn) RateDiv = RATE_W'($urandom_range(0, 5));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
